// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int unsigned MUL_LAT_DEF = 4;
   localparam int unsigned DIV_LAT_DEF = 16;

   // Smallest countdown width able to hold max(mul_lat, div_lat) - 1.
   function automatic int unsigned cnt_w_for(input int unsigned mul_lat,
                                             input int unsigned div_lat);
      int unsigned m;
      int unsigned w;
      m = ((mul_lat > div_lat) ? mul_lat : div_lat) - 1;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((m >> i) != 0) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Mult/div latency countdown: loads a start value, counts down to zero and holds.
module md_timer #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencing and HI/LO mult/div issue handshake.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles / md_cycles performance counters.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
   parameter int unsigned MUL_LAT = MUL_LAT_DEF,
   parameter int unsigned DIV_LAT = DIV_LAT_DEF,
   parameter int unsigned CNT_W   = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hz_req,
   input  logic lu_req,
   input  logic br_taken,
   input  logic md_req,
   input  logic md_div,
   input  logic md_use,
   output logic pc_we,
   output logic ifid_we,
   output logic ifid_flush,
   output logic idex_flush,
   output logic md_go,
   output logic md_busy,
   output logic md_done
`ifdef PIPE_CTRL_PERF_EN
  ,output logic [31:0] stall_cycles,
   output logic [31:0] md_cycles
`endif
);

   state_t           state;
   logic             flush_pend;
   logic             md_block;
   logic             stall;
   logic             issue;
   logic             cnt_zero;
   logic [CNT_W-1:0] load_val;

   assign md_block = (state == BUSY) & (md_req | md_use);
   assign stall    = hz_req | lu_req | md_block;
   assign issue    = (state == RUN) & md_req & ~stall;
   assign load_val = md_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

   md_timer #(
      .CNT_W(CNT_W)
   ) u_md_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (issue),
      .load_val(load_val),
      .zero    (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         flush_pend <= 1'b0;
      end else begin
         unique case (state)
            RUN:  if (issue)    state <= BUSY;
            BUSY: if (cnt_zero) state <= RUN;
            default:            state <= RUN;
         endcase
         // A redirect seen under stall is held until the first unstalled cycle.
         flush_pend <= stall & (flush_pend | br_taken);
      end
   end

   // Outputs are qualified by rst_n so the pipeline is frozen while reset is held.
   assign pc_we      = rst_n & ~stall;
   assign ifid_we    = rst_n & ~stall;
   assign idex_flush = rst_n & stall;
   assign ifid_flush = rst_n & ~stall & (br_taken | flush_pend);
   assign md_go      = rst_n & issue;
   assign md_busy    = rst_n & (state == BUSY);
   assign md_done    = rst_n & (state == BUSY) & cnt_zero;

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         md_cycles    <= '0;
      end else begin
         if (stall)          stall_cycles <= stall_cycles + 32'd1;
         if (state == BUSY)  md_cycles    <= md_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a timestamp-based behavioural model.
module tb_pipe_ctrl;

   localparam int MUL = 4;
   localparam int DIV = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hz_req = 1'b0, lu_req = 1'b0, br_taken = 1'b0;
   logic md_req = 1'b0, md_div = 1'b0, md_use = 1'b0;
   logic pc_we, ifid_we, ifid_flush, idex_flush, md_go, md_busy, md_done;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles, md_cycles;
`endif

   pipe_ctrl #(
      .MUL_LAT(MUL),
      .DIV_LAT(DIV),
      .CNT_W  (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hz_req    (hz_req),
      .lu_req    (lu_req),
      .br_taken  (br_taken),
      .md_req    (md_req),
      .md_div    (md_div),
      .md_use    (md_use),
      .pc_we     (pc_we),
      .ifid_we   (ifid_we),
      .ifid_flush(ifid_flush),
      .idex_flush(idex_flush),
      .md_go     (md_go),
      .md_busy   (md_busy),
      .md_done   (md_done)
`ifdef PIPE_CTRL_PERF_EN
     ,.stall_cycles(stall_cycles),
      .md_cycles   (md_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Model: the unit is busy in cycles (go_at, go_at+lat]; done in the last of them.
   int   now = 0;
   int   go_at = -1;
   int   lat_cur = 0;
   bit   fp = 1'b0;
   bit   m_stall = 1'b0, m_go = 1'b0, m_br = 1'b0, m_div = 1'b0, m_busy = 1'b0;
   int   m_stall_cnt = 0, m_busy_cnt = 0;
   logic [6:0] exp_v = '0;

   function automatic logic [6:0] obs();
      return {pc_we, ifid_we, ifid_flush, idex_flush, md_go, md_busy, md_done};
   endfunction

   task automatic model_eval();
      bit busy, done, flush;
      busy  = (go_at >= 0) && (now > go_at) && (now <= go_at + lat_cur);
      done  = busy && (now == go_at + lat_cur);
      m_stall = hz_req | lu_req | (busy & (md_req | md_use));
      m_go    = md_req & ~m_stall & ~busy;
      m_br    = br_taken;
      m_div   = md_div;
      m_busy  = busy;
      flush   = ~m_stall & (br_taken | fp);
      exp_v   = {~m_stall, ~m_stall, flush, m_stall, m_go, busy, done};
   endtask

   // One clock cycle: commit the previous cycle into the model, apply new inputs, settle.
   task automatic cyc(input bit h, input bit l, input bit b, input bit r, input bit d, input bit u);
      @(posedge clk);
      #1;
      if (m_go) begin
         go_at   = now;
         lat_cur = m_div ? DIV : MUL;
      end
      fp = m_stall & (fp | m_br);
      m_stall_cnt += int'(m_stall);
      m_busy_cnt  += int'(m_busy);
      now++;
      hz_req = h; lu_req = l; br_taken = b; md_req = r; md_div = d; md_use = u;
      model_eval();
      @(negedge clk);
   endtask

   task automatic model_reset();
      go_at = -1; fp = 1'b0;
      m_stall = 1'b0; m_go = 1'b0; m_br = 1'b0; m_busy = 1'b0;
      m_stall_cnt = 0; m_busy_cnt = 0;
      exp_v = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hz_req = 1'b0; lu_req = 1'b0; br_taken = 1'b1; md_req = 1'b1; md_div = 1'b0; md_use = 1'b0;
      #2;
      checks++;
      if (obs() !== 7'b0) $display("FAIL reset_hold got %b want %b", obs(), 7'b0);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (obs() !== 7'b0) $display("FAIL reset_hold_edge got %b want %b", obs(), 7'b0);
      else passed++;
      @(negedge clk);
      br_taken = 1'b0; md_req = 1'b0;
      model_reset();
      rst_n = 1'b1;
      #1;
      model_eval();
      checks++;
      if (obs() !== exp_v) $display("FAIL reset_release got %b want %b", obs(), exp_v);
      else passed++;
   endtask

   task automatic test_hz_stall();
      int bubbles = 0;
      cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc((i == 1 || i == 2), 0, 0, 0, 0, 0);
         bubbles += int'(idex_flush);
         checks++;
         if (obs() !== exp_v) $display("FAIL hz_stall c%0d got %b want %b", i, obs(), exp_v);
         else passed++;
      end
      checks++;
      if (bubbles !== 2) $display("FAIL hz_bubbles got %0d want 2", bubbles);
      else passed++;
   endtask

   task automatic test_mul();
      int busy_n = 0, done_n = 0, done_at = -1;
      cyc(0, 0, 0, 1, 0, 0);
      checks++;
      if (obs() !== exp_v) $display("FAIL mul_go got %b want %b", obs(), exp_v);
      else passed++;
      for (int i = 1; i <= 6; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         busy_n += int'(md_busy);
         if (md_done) begin done_n++; done_at = i; end
         checks++;
         if (obs() !== exp_v) $display("FAIL mul c%0d got %b want %b", i, obs(), exp_v);
         else passed++;
      end
      checks++;
      if (busy_n !== MUL || done_n !== 1 || done_at !== MUL)
         $display("FAIL mul_timing got busy=%0d done=%0d@%0d want busy=%0d done=1@%0d",
                  busy_n, done_n, done_at, MUL, MUL);
      else passed++;
   endtask

   task automatic test_div_use();
      int stalls = 0, release_at = -1, done_at = -1;
      cyc(0, 0, 0, 1, 1, 0);
      for (int i = 1; i <= 18; i++) begin
         cyc(0, 0, 0, 0, 0, (i >= 3 && release_at < 0));
         stalls += int'(idex_flush);
         if (md_done) done_at = i;
         if (i >= 3 && pc_we && release_at < 0) release_at = i;
         checks++;
         if (obs() !== exp_v) $display("FAIL div_use c%0d got %b want %b", i, obs(), exp_v);
         else passed++;
      end
      checks++;
      if (stalls !== 14 || release_at !== 17 || done_at !== 16)
         $display("FAIL div_use_timing got stalls=%0d rel=%0d done=%0d want 14 17 16",
                  stalls, release_at, done_at);
      else passed++;
   endtask

   task automatic test_deferred_flush();
      bit [2:0] seen;
      cyc(0, 1, 1, 0, 0, 0);
      seen[0] = ifid_flush;
      checks++;
      if (obs() !== exp_v) $display("FAIL defer_hold got %b want %b", obs(), exp_v);
      else passed++;
      cyc(0, 0, 0, 0, 0, 0);
      seen[1] = ifid_flush;
      checks++;
      if (obs() !== exp_v) $display("FAIL defer_fire got %b want %b", obs(), exp_v);
      else passed++;
      cyc(0, 0, 0, 0, 0, 0);
      seen[2] = ifid_flush;
      checks++;
      if (seen !== 3'b010) $display("FAIL defer_seq got %b want 010", seen);
      else passed++;
      // Deferred flush colliding with a fresh redirect: one pulse, then clear.
      cyc(1, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      checks++;
      if (obs() !== exp_v) $display("FAIL defer_merge got %b want %b", obs(), exp_v);
      else passed++;
      cyc(0, 0, 0, 0, 0, 0);
      checks++;
      if (ifid_flush !== 1'b0) $display("FAIL defer_merge_clear got %b want 0", ifid_flush);
      else passed++;
   endtask

   task automatic test_reset_mid_op();
      bit done_seen = 1'b0;
      cyc(0, 0, 0, 1, 1, 0);
      cyc(0, 0, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      hz_req = 1'b0; lu_req = 1'b0; br_taken = 1'b0; md_req = 1'b0; md_use = 1'b0;
      #1;
      checks++;
      if (obs() !== 7'b0) $display("FAIL rst_mid_async got %b want %b", obs(), 7'b0);
      else passed++;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, (i == 0), 0, 0);
         if (md_done && i < MUL) done_seen = 1'b1;
         checks++;
         if (obs() !== exp_v) $display("FAIL rst_mid_after c%0d got %b want %b", i, obs(), exp_v);
         else passed++;
      end
      checks++;
      if (done_seen !== 1'b0) $display("FAIL rst_mid_no_done got %b want 0", done_seen);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(99) < 12), ($urandom_range(99) < 8), ($urandom_range(99) < 20),
             ($urandom_range(99) < 30), ($urandom_range(99) < 35), ($urandom_range(99) < 15));
         checks++;
         if (obs() !== exp_v) $display("FAIL random c%0d got %b want %b", now, obs(), exp_v);
         else passed++;
      end
      for (int i = 0; i < DIV + 2; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      int go_cyc[$];
      for (int i = 0; i < 14; i++) begin
         cyc(0, 0, 0, 1, 0, 0);
         if (md_go) go_cyc.push_back(i);
         checks++;
         if (obs() !== exp_v) $display("FAIL b2b c%0d got %b want %b", i, obs(), exp_v);
         else passed++;
      end
      cyc(0, 0, 0, 0, 0, 0);
      checks++;
      if (go_cyc.size() !== 3 || go_cyc[0] !== 0 || go_cyc[1] !== MUL + 1 || go_cyc[2] !== 2 * (MUL + 1))
         $display("FAIL b2b_spacing got n=%0d want 3 issues at 0,%0d,%0d", go_cyc.size(), MUL + 1, 2 * (MUL + 1));
      else passed++;
      for (int i = 0; i < MUL + 1; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

`ifdef PIPE_CTRL_PERF_EN
   task automatic test_perf();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < MUL + 3; i++) cyc(0, 0, 0, 0, 0, 0);
      checks++;
      if (stall_cycles !== 32'd3 || stall_cycles !== 32'(m_stall_cnt))
         $display("FAIL perf_stall got %0d want 3", stall_cycles);
      else passed++;
      checks++;
      if (md_cycles !== 32'(MUL) || md_cycles !== 32'(m_busy_cnt))
         $display("FAIL perf_md got %0d want %0d", md_cycles, MUL);
      else passed++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_hz_stall();
      test_mul();
      test_div_use();
      test_deferred_flush();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
`ifdef PIPE_CTRL_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
